// File: rtl/pipeline_pkg.sv
// Shared pipeline types: default register-file geometry plus the address and
// word types that decode and writeback use for the default build.
package pipeline_pkg;

    localparam int DEFAULT_DATA_W = 20;
    localparam int DEFAULT_ADDR_W = 4;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits: flush clears everything, an issue sets,
// a writeback clears, and an issue beats a same-cycle writeback.
module regfile_scoreboard
    import pipeline_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 0
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 IssueValid,
    input  logic [ADDR_W-1:0]    IssueReg,
    input  logic                 WriteEnable,
    input  logic [ADDR_W-1:0]    WriteReg,
    input  logic                 Flush,
    output logic [2**ADDR_W-1:0] BusyVec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busyReg;
    logic [DEPTH-1:0] busyNext;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : gBusy
        if (ZERO_REG != 0 && gi == 0) begin : gZero
            assign busyNext[gi] = 1'b0;
        end else begin : gLive
            always_comb begin
                busyNext[gi] = busyReg[gi];
                if (Flush)
                    busyNext[gi] = 1'b0;
                else if (IssueValid && IssueReg == ADDR_W'(gi))
                    busyNext[gi] = 1'b1;
                else if (WriteEnable && WriteReg == ADDR_W'(gi))
                    busyNext[gi] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            busyReg <= '0;
        else
            busyReg <= busyNext;
    end

    assign BusyVec = busyReg;

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with two combinational read ports, one synchronous write port,
// optional write-through bypass, optional hard-wired r0 and a RAW scoreboard.
module scoreboard_regfile
    import pipeline_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [ADDR_W-1:0]    RegReadAddress1,
    input  logic [ADDR_W-1:0]    RegReadAddress2,
    output logic [DATA_W-1:0]    DataOut1,
    output logic [DATA_W-1:0]    DataOut2,
    output logic                 Busy1,
    output logic                 Busy2,
    input  logic                 WriteEnable,
    input  logic [ADDR_W-1:0]    WriteReg,
    input  logic [DATA_W-1:0]    WriteData,
    input  logic                 IssueValid,
    input  logic [ADDR_W-1:0]    IssueReg,
    input  logic                 Flush,
    output logic [2**ADDR_W-1:0] BusyVec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regsReg [DEPTH];
    logic              writeOk;
    logic [ADDR_W-1:0] rdAddr  [2];
    logic [DATA_W-1:0] rdData  [2];
    logic              rdBusy  [2];

    assign writeOk = WriteEnable && !(ZERO_REG != 0 && WriteReg == '0);

    // Storage is cleared on reset too, so it maps to registers rather than RAM.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++)
                regsReg[i] <= '0;
        end else if (writeOk) begin
            regsReg[WriteReg] <= WriteData;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) uScoreboard (
        .clock       (clock),
        .resetn      (resetn),
        .IssueValid  (IssueValid),
        .IssueReg    (IssueReg),
        .WriteEnable (WriteEnable),
        .WriteReg    (WriteReg),
        .Flush       (Flush),
        .BusyVec     (BusyVec)
    );

    assign rdAddr[0] = RegReadAddress1;
    assign rdAddr[1] = RegReadAddress2;

    for (genvar gi = 0; gi < 2; gi++) begin : gRead
        logic fwdHit;
        logic zeroHit;

        assign fwdHit  = (BYPASS != 0) && WriteEnable && (WriteReg == rdAddr[gi]);
        assign zeroHit = (ZERO_REG != 0) && (rdAddr[gi] == '0);

        always_comb begin
            rdData[gi] = regsReg[rdAddr[gi]];
            if (zeroHit)
                rdData[gi] = '0;
            else if (fwdHit)
                rdData[gi] = WriteData;
        end

        // A forwarded operand is no longer a hazard this cycle.
        assign rdBusy[gi] = BusyVec[rdAddr[gi]] && !fwdHit;
    end

    assign DataOut1 = rdData[0];
    assign DataOut2 = rdData[1];
    assign Busy1    = rdBusy[0];
    assign Busy2    = rdBusy[1];

endmodule

// File: doc/scoreboard_regfile.md
# scoreboard_regfile

Parametrised register file for the pipeline processor. Two combinational read ports, one synchronous write port, and a per-register pending-write scoreboard. It generalises the fixed 16×20-bit file with configurable width and depth, synchronous clear, optional hard-wired zero register and write-through bypass. The scoreboard lets decode detect RAW hazards without a separate hazard unit.

## Interface
Parameters:
- DATA_W, 20, data word width
- ADDR_W, 4, address width; depth = 2**ADDR_W
- ZERO_REG, 0, 1 makes register 0 read as zero and ignore writes and issues
- BYPASS, 1, 1 makes a read of the address being written this cycle return WriteData

Ports:
- clock  in  1  single clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- RegReadAddress1  in  ADDR_W  read port 1 address
- RegReadAddress2  in  ADDR_W  read port 2 address
- DataOut1  out  DATA_W  read port 1 data (combinational)
- DataOut2  out  DATA_W  read port 2 data (combinational)
- Busy1  out  1  pending write outstanding on RegReadAddress1
- Busy2  out  1  pending write outstanding on RegReadAddress2
- WriteEnable  in  1  writeback strobe
- WriteReg  in  ADDR_W  writeback destination
- WriteData  in  DATA_W  writeback data
- IssueValid  in  1  an instruction with a destination leaves decode
- IssueReg  in  ADDR_W  destination of the issuing instruction
- Flush  in  1  clears every busy bit (pipeline squash)
- BusyVec  out  2**ADDR_W  raw scoreboard state

## Operation
- Storage: 2**ADDR_W words of DATA_W bits. On a rising edge with resetn=1 and WriteEnable=1, word[WriteReg] <= WriteData.
- Reads:
  - DataOutN = word[RegReadAddressN].
  - With BYPASS=1, if WriteEnable and WriteReg==RegReadAddressN, DataOutN = WriteData.
  - With ZERO_REG=1, address 0 always reads 0, bypass included.
- Scoreboard: busy[i] is one bit per register.
  - Next-state priority: resetn=0 → 0; Flush → 0 for all; else set if IssueValid & IssueReg==i; else clear if WriteEnable & WriteReg==i; else hold.
  - Issue and writeback to the same register in the same cycle: set wins, because the new producer is still outstanding.
  - Flush and a simultaneous issue: flush wins and the issue is dropped.
  - Writeback to a non-busy register: the write happens and busy stays 0.
- BusyN = busy[RegReadAddressN], masked to 0 when BYPASS=1 and WriteEnable & WriteReg==RegReadAddressN, because the data is forwarded this cycle.
- ZERO_REG=1: busy[0] is constant 0 and writes to 0 are discarded.
- Reset: every word is 0 and every busy bit is 0. The storage array is cleared synchronously as well. After reset, DataOut1/2=0, Busy1/2=0 and BusyVec=0.

## Timing
- Read latency 0 (combinational from address). Write latency 1 edge; the bypass hides it within the same cycle.
- The scoreboard updates on the same edge as the write. An issue in cycle n shows BusyN=1 from cycle n+1.
- Reset mid-operation: at the first edge with resetn=0, all state clears. Inputs presented in that cycle are ignored.
- Flush takes effect at the next edge. Storage contents are untouched by Flush.
- No combinational path from IssueValid/IssueReg/Flush to any output.

## Structure
- Shared package pipeline_pkg: DATA_W and ADDR_W defaults, plus the reg_addr_t and word_t typedefs used by decode and writeback.
- One sub-module: regfile_scoreboard (busy bits, set/clear/flush priority, BusyVec). The storage array and read muxes stay in the top module.
- The block is a drop-in replacement for the existing 20-bit, 16-entry file when the ports are tied off: IssueValid=0, Flush=0, BYPASS=0. In that mode writes land on the rising edge instead of the falling edge.

## Test plan
- Reset then read all 16 addresses → every DataOut=0, BusyVec=0.
- Write 0x00001 to r1, then 0x00002 to r2 on consecutive edges; read r1/r2 → 0x00001 / 0x00002. In the write cycle with BYPASS=1, reading r2 returns 0x00002.
- Issue r5 at cycle n → Busy1=1 at n+1 with RegReadAddress1=5. Writeback r5=0xABCDE at n+3 → Busy1=0 combinationally that cycle, DataOut1=0xABCDE, busy[5]=0 after the edge.
- Same-cycle issue r3 and writeback r3 → data written and busy[3]=1 after the edge. Flush with simultaneous issue r4 → BusyVec=0.
- ZERO_REG=1: write 0xFFFFF to r0 and issue r0 → DataOut=0, busy[0]=0. DATA_W=32, ADDR_W=5 build: write/read r31 = 0xDEADBEEF.
- Assert resetn=0 for one cycle while r7 is busy and holds 0x12345 → next cycle DataOut(r7)=0 and BusyVec=0.
